// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the register-map bus arbiter.
package bus_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

   // Index width for a requester count; never narrower than one bit.
   function automatic int gid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bus_req_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int N = 2
) (
   input  logic [N-1:0]              req,
   input  logic [gid_width(N)-1:0]   ptr,
   output logic [N-1:0]              grant,
   output logic [gid_width(N)-1:0]   idx,
   output logic                      any
);

   localparam int GW = gid_width(N);

   int unsigned j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         // explicit wrap keeps non-power-of-2 N correct
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = GW'(j);
         end
      end
   end

endmodule

// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter sharing one register-map bus port between N_REQ masters,
// one outstanding transaction at a time, with an optional per-access timeout.
module bus_req_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 11,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              up_req,
   input  logic [N_REQ-1:0]              up_req_is_wr,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   up_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0]   up_wr_data,
   input  logic [N_REQ*DATA_WIDTH-1:0]   up_wr_biten,
   output logic [N_REQ-1:0]              up_ready,
   output logic                          up_err,
   output logic [DATA_WIDTH-1:0]         up_rd_data,
   output logic                          bus_req,
   output logic                          bus_req_is_wr,
   output logic [ADDR_WIDTH-1:0]         bus_addr,
   output logic [DATA_WIDTH-1:0]         bus_wr_data,
   output logic [DATA_WIDTH-1:0]         bus_wr_biten,
   output logic                          bus_req_stall_wr,
   output logic                          bus_req_stall_rd,
   input  logic                          bus_ready,
   input  logic                          bus_err,
   input  logic [DATA_WIDTH-1:0]         bus_rd_data,
   output logic [gid_width(N_REQ)-1:0]   grant_id,
   output logic                          busy,
   output logic                          timeout_evt
);

   localparam int              GW      = gid_width(N_REQ);
   localparam int              CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0]   TO_MAX  = CW'(TIMEOUT_CYCLES);
   localparam logic [GW-1:0]   LAST_ID = GW'(N_REQ - 1);

   arb_state_e         state, state_nxt;
   logic [GW-1:0]      rr_ptr;
   logic [GW-1:0]      pick_idx;
   logic [N_REQ-1:0]   pick_grant;
   logic               pick_any;
   logic [N_REQ-1:0]   grant_oh;
   logic [CW-1:0]      to_cnt;
   logic               to_hit;
   logic               resp_err;

   rr_pick #(.N(N_REQ)) u_pick (
      .req   (up_req),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // bus_ready takes priority over a coinciding timeout
   assign to_hit = (TIMEOUT_CYCLES != 0) && (state == WAIT) && !bus_ready && (to_cnt == TO_MAX);

   assign bus_req_stall_wr = 1'b0;
   assign bus_req_stall_rd = 1'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (pick_any) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (bus_ready || to_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus_req  = (state == ISSUE);
      busy     = (state != IDLE);
      up_ready = (state == RESP) ? grant_oh : '0;
      up_err   = (state == RESP) && resp_err;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr        <= '0;
         grant_id      <= '0;
         grant_oh      <= '0;
         bus_req_is_wr <= 1'b0;
         bus_addr      <= '0;
         bus_wr_data   <= '0;
         bus_wr_biten  <= '0;
         to_cnt        <= '0;
         resp_err      <= 1'b0;
         up_rd_data    <= '0;
         timeout_evt   <= 1'b0;
      end else begin
         timeout_evt <= to_hit;
         unique case (state)
            IDLE: if (pick_any) begin
               grant_id      <= pick_idx;
               grant_oh      <= pick_grant;
               bus_req_is_wr <= up_req_is_wr[pick_idx];
               bus_addr      <= up_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
               bus_wr_data   <= up_wr_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
               bus_wr_biten  <= up_wr_biten[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            ISSUE: to_cnt <= '0;
            WAIT: begin
               if (bus_ready) begin
                  resp_err   <= bus_err;
                  up_rd_data <= bus_req_is_wr ? '0 : bus_rd_data;
               end else if (to_hit) begin
                  resp_err   <= 1'b1;
                  up_rd_data <= '0;
               end else if (to_cnt != '1) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            RESP: rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_req_arbiter.sv
// Directed bench for bus_req_arbiter (N_REQ=2, TIMEOUT_CYCLES=4).
module tb_bus_req_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 11;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    up_req, up_req_is_wr, up_ready;
   logic [N*AW-1:0] up_addr;
   logic [N*DW-1:0] up_wr_data, up_wr_biten;
   logic            up_err;
   logic [DW-1:0]   up_rd_data;
   logic            bus_req, bus_req_is_wr, bus_req_stall_wr, bus_req_stall_rd;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_wr_data, bus_wr_biten, bus_rd_data;
   logic            bus_ready, bus_err;
   logic [0:0]      grant_id;
   logic            busy, timeout_evt;

   int n_chk  = 0;
   int n_pass = 0;

   bus_req_arbiter #(
      .N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .up_req(up_req), .up_req_is_wr(up_req_is_wr), .up_addr(up_addr),
      .up_wr_data(up_wr_data), .up_wr_biten(up_wr_biten),
      .up_ready(up_ready), .up_err(up_err), .up_rd_data(up_rd_data),
      .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
      .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
      .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd),
      .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data),
      .grant_id(grant_id), .busy(busy), .timeout_evt(timeout_evt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered in an IDLE cycle with the request set; returns in the RESP cycle.
   task automatic serve(input string tag, input int gid, input logic [AW-1:0] addr,
                        input logic is_wr, input logic [DW-1:0] rdata,
                        input logic err, input logic [DW-1:0] exp_rd);
      logic [N-1:0] exp_rdy;
      exp_rdy = 2'b01 << gid;
      step();
      check({tag, ".bus_req"},  bus_req, 1);
      check({tag, ".grant_id"}, grant_id, gid);
      check({tag, ".bus_addr"}, bus_addr, addr);
      check({tag, ".is_wr"},    bus_req_is_wr, is_wr);
      step();
      check({tag, ".bus_req_off"}, bus_req, 0);
      bus_ready   = 1'b1;
      bus_rd_data = rdata;
      bus_err     = err;
      step();
      bus_ready   = 1'b0;
      bus_err     = 1'b0;
      bus_rd_data = '0;
      check({tag, ".up_ready"},   up_ready, exp_rdy);
      check({tag, ".up_err"},     up_err, err);
      check({tag, ".up_rd_data"}, up_rd_data, exp_rd);
      check({tag, ".timeout"},    timeout_evt, 0);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, ".busy"},      busy, 0);
      check({tag, ".bus_req"},   bus_req, 0);
      check({tag, ".up_ready"},  up_ready, 0);
      check({tag, ".up_err"},    up_err, 0);
      check({tag, ".grant_id"},  grant_id, 0);
      check({tag, ".bus_addr"},  bus_addr, 0);
      check({tag, ".rd_data"},   up_rd_data, 0);
      check({tag, ".timeout"},   timeout_evt, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      up_req = '0; up_req_is_wr = '0; up_addr = '0;
      up_wr_data = '0; up_wr_biten = '0;
      bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = '0;
      step(); step();
      check_idle_zero("reset");
      check("reset.stall_wr", bus_req_stall_wr, 0);
      check("reset.stall_rd", bus_req_stall_rd, 0);
      check("reset.wr_data",  bus_wr_data, 0);
      rst = 1'b1;
      step();

      // single read from requester 0
      up_req = 2'b01; up_req_is_wr = 2'b00; up_addr[0 +: AW] = 11'h010;
      serve("rd", 0, 11'h010, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
      up_req = '0;
      step();
      check("rd.idle_busy",  busy, 0);
      check("rd.idle_rdy",   up_ready, 0);
      check("rd.hold_data",  up_rd_data, 32'hDEADBEEF);

      // write from requester 1, junk on requester 0 fields
      up_req = 2'b10; up_req_is_wr = 2'b10;
      up_addr[0 +: AW] = 11'h123;        up_addr[AW +: AW] = 11'h7FF;
      up_wr_data[0 +: DW] = 32'hAAAAAAAA; up_wr_data[DW +: DW] = 32'h12345678;
      up_wr_biten[0 +: DW] = 32'hFFFFFFFF; up_wr_biten[DW +: DW] = 32'h0000FFFF;
      serve("wr", 1, 11'h7FF, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0);
      check("wr.wr_data", bus_wr_data, 32'h12345678);
      check("wr.biten",   bus_wr_biten, 32'h0000FFFF);
      up_req = '0; up_req_is_wr = '0;
      step();

      // contention: both held, expect 0,1,0,1
      up_req = 2'b11;
      up_addr[0 +: AW] = 11'h100; up_addr[AW +: AW] = 11'h200;
      for (int i = 0; i < 4; i++) begin
         serve($sformatf("rr%0d", i), i % 2, (i % 2) ? 11'h200 : 11'h100,
               1'b0, 32'hC0DE0000 + i, 1'b0, 32'hC0DE0000 + i);
         if (i == 3) up_req = '0;
         step();
      end

      // error pass-through
      up_req = 2'b01;
      serve("err", 0, 11'h100, 1'b0, 32'hBAD0BAD0, 1'b1, 32'hBAD0BAD0);
      up_req = '0;
      step();

      // timeout on requester 1; requester drops request while granted
      up_req = 2'b10;
      step();
      check("to.bus_req",  bus_req, 1);
      check("to.grant_id", grant_id, 1);
      up_req = '0;
      for (int c = 1; c <= 5; c++) begin
         step();
         check($sformatf("to.wait%0d_rdy", c), up_ready, 0);
         check($sformatf("to.wait%0d_evt", c), timeout_evt, 0);
      end
      step();
      check("to.evt",     timeout_evt, 1);
      check("to.ready",   up_ready, 2'b10);
      check("to.err",     up_err, 1);
      check("to.rd_data", up_rd_data, 0);
      step();
      bus_ready = 1'b1; bus_err = 1'b1; bus_rd_data = 32'hFFFFFFFF;
      step(); step();
      check("stray.busy",    busy, 0);
      check("stray.ready",   up_ready, 0);
      check("stray.rd_data", up_rd_data, 0);
      check("stray.evt",     timeout_evt, 0);
      bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = '0;

      // grant 0 so the pointer moves to 1 before the reset test
      up_req = 2'b01;
      serve("pre", 0, 11'h100, 1'b0, 32'h11, 1'b0, 32'h11);
      up_req = '0;
      step();

      // reset while WAITing on requester 1
      up_req = 2'b10;
      step();
      check("rw.grant_id", grant_id, 1);
      step();
      rst = 1'b0;
      #1;
      check_idle_zero("rw");
      up_req = '0;
      step();
      check("rw.held_rdy", up_ready, 0);
      rst = 1'b1;
      step();
      check("rw.after_rdy", up_ready, 0);

      // pointer back at 0: requester 0 wins, then requester 1 alone
      up_req = 2'b11;
      serve("post0", 0, 11'h100, 1'b0, 32'h22, 1'b0, 32'h22);
      up_req = 2'b10;
      step();
      serve("post1", 1, 11'h200, 1'b0, 32'h33, 1'b0, 32'h33);
      up_req = '0;
      step();
      check("end.busy", busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
